// File: rtl/led_pio_write_arbiter_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package led_pio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int         LED_W_DEF     = 17;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/led_pio_write_arbiter_if.sv
// Avalon-MM write-only bus toward the LED PIO slave (s1).
interface led_pio_write_arbiter_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_waitrequest
  );

endinterface

// File: rtl/led_pio_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = |req;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/led_pio_write_arbiter.sv
// Round-robin Avalon-MM master sharing the LED PIO data register among NUM_REQ requesters.
// Optional self-blink requester enabled by defining LED_BLINK_EN.
module led_pio_write_arbiter
  import led_pio_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LED_W     = LED_W_DEF,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [LED_W-1:0]         led_shadow,
  input  logic [LED_W-1:0]         blink_mask,
  led_pio_write_arbiter_if.master  avm
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      winner;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] grant_q;
  logic [IW-1:0]      grant_idx;
  logic               grant_vld;
  logic               blink_wr;
  logic               blink_req;
  logic               chipselect_q;
  logic               write_n_q;
  logic [31:0]        writedata_q;
  logic [LED_W-1:0]   sel_data;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .vld   (grant_vld)
  );

  assign sel_data = req_data[grant_idx*LED_W +: LED_W];

`ifdef LED_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] blink_cnt;
  logic          blink_tick;
  logic          blink_pending;
  logic          blink_clr;

  assign blink_tick = (blink_cnt == CW'(BLINK_DIV - 1));
  // Cleared when the slave takes the blink write, or when a zero mask makes it a no-op.
  assign blink_clr  = (state == WRITE && blink_wr && !avm.avm_waitrequest) ||
                      (state == IDLE && req == '0 && blink_pending && blink_mask == '0);
  assign blink_req  = blink_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt     <= '0;
      blink_pending <= 1'b0;
    end else begin
      blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
      if (blink_tick)
        blink_pending <= 1'b1;
      else if (blink_clr)
        blink_pending <= 1'b0;
    end
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  assign blink_req = 1'b0;
`endif

  // state | meaning
  // IDLE  | bus idle; pick next requester (blink only when no req)
  // WRITE | bus driving latched data; wait for waitrequest low
  // ACK   | one-cycle ack to the winner (none for blink); bus idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      winner       <= '0;
      grant_q      <= '0;
      blink_wr     <= 1'b0;
      ack          <= '0;
      busy         <= 1'b0;
      led_shadow   <= '0;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            winner       <= grant_idx;
            grant_q      <= grant;
            blink_wr     <= 1'b0;
            writedata_q  <= 32'(sel_data);
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            busy         <= 1'b1;
            state        <= WRITE;
          end else if (blink_req && blink_mask != '0) begin
            grant_q      <= '0;
            blink_wr     <= 1'b1;
            writedata_q  <= 32'(led_shadow ^ blink_mask);
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            busy         <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (!avm.avm_waitrequest) begin
            led_shadow   <= writedata_q[LED_W-1:0];
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            state        <= ACK;
            if (!blink_wr) begin
              ack    <= grant_q;
              rr_ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign avm.avm_address    = PIO_DATA_ADDR;
  assign avm.avm_chipselect = chipselect_q;
  assign avm.avm_write_n    = write_n_q;
  assign avm.avm_writedata  = writedata_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench for led_pio_write_arbiter with a write/ack scoreboard.
// Blink scenario runs only when LED_BLINK_EN is defined.
module tb_led_pio_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LED_W   = 17;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [LED_W-1:0]         led_shadow;
  logic [LED_W-1:0]         blink_mask;

  led_pio_write_arbiter_if avm_if();

  led_pio_write_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .LED_W     (LED_W),
    .BLINK_DIV (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .busy       (busy),
    .led_shadow (led_shadow),
    .blink_mask (blink_mask),
    .avm        (avm_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   ack_pend = 1'b0;
  int   ack_id   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted bus write pops one entry; the next cycle must carry its ack.
  always @(negedge clk) begin
    if (reset) begin
      ack_pend = 1'b0;
    end else begin
      check("ack_scoreboard", 32'(ack),
            (ack_pend && ack_id >= 0) ? (32'(1) << ack_id) : 32'h0);
      ack_pend = 1'b0;
      if (avm_if.avm_chipselect && !avm_if.avm_write_n && !avm_if.avm_waitrequest) begin
        check("unexpected_write", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("writedata", avm_if.avm_writedata, mon_e.data);
          check("address", 32'(avm_if.avm_address), 32'd0);
          ack_pend = 1'b1;
          ack_id   = mon_e.id;
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(int i, logic [LED_W-1:0] v);
    req_data[i*LED_W +: LED_W] = v;
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_cs"},     32'(avm_if.avm_chipselect), 32'd0);
    check({tag, "_wn"},     32'(avm_if.avm_write_n),    32'd1);
    check({tag, "_addr"},   32'(avm_if.avm_address),    32'd0);
    check({tag, "_wdata"},  avm_if.avm_writedata,       32'd0);
    check({tag, "_ack"},    32'(ack),                   32'd0);
    check({tag, "_busy"},   32'(busy),                  32'd0);
    check({tag, "_shadow"}, 32'(led_shadow),            32'd0);
  endtask

  task automatic do_reset();
    next_cyc();
    reset = 1'b1;
    req   = '0;
    avm_if.avm_waitrequest = 1'b0;
    #1;
    next_cyc();
    reset = 1'b0;
  endtask

  task automatic wait_ack(string tag);
    int n = 0;
    do begin
      sample();
      n++;
    end while (ack == '0 && n < 20);
    check(tag, 32'(ack != '0), 32'd1);
  endtask

  task automatic wait_empty(string tag, int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      sample();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int last_cyc;
    logic [LED_W-1:0] d [NUM_REQ];
    int order [5];

    reset      = 1'b1;
    req        = '0;
    req_data   = '0;
    blink_mask = '0;
    avm_if.avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Single write: bus in cycle 1, ack in cycle 2.
    set_data(0, 17'h1ABCD);
    req = 4'b0001;
    exp_q.push_back('{32'h0001ABCD, 0});
    next_cyc();
    sample();
    check("t1_cs",    32'(avm_if.avm_chipselect), 32'd1);
    check("t1_wn",    32'(avm_if.avm_write_n),    32'd0);
    check("t1_wdata", avm_if.avm_writedata,       32'h0001ABCD);
    check("t1_busy",  32'(busy),                  32'd1);
    check("t1_ack_early", 32'(ack),               32'd0);
    next_cyc();
    sample();
    check("t1_ack", 32'(ack), 32'b0001);
    req = '0;
    next_cyc();
    sample();
    check("t1_shadow", 32'(led_shadow), 32'h1ABCD);
    check("t1_idle",   32'(busy),       32'd0);

    // All four requesting: round-robin 0,1,2,3,0 with a 3-cycle period.
    do_reset();
    check("t2_shadow_reset", 32'(led_shadow), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) begin
      d[i] = LED_W'(32'h100F0 + i * 32'h1111);
      set_data(i, d[i]);
    end
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{32'(d[order[k]]), order[k]});
    req = 4'b1111;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack("t2_ack_timeout");
      check("t2_single_ack", 32'($countones(ack)), 32'd1);
      if (k > 0)
        check("t2_period", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
    end
    req = '0;
    next_cyc();

    // Slave stalls five cycles; bus must hold and later req_data changes are ignored.
    avm_if.avm_waitrequest = 1'b1;
    set_data(2, 17'h0AAAA);
    req = 4'b0100;
    exp_q.push_back('{32'h0000AAAA, 2});
    for (int c = 1; c <= 5; c++) begin
      next_cyc();
      if (c == 2)
        set_data(2, 17'h15555);
      sample();
      check("t3_cs",    32'(avm_if.avm_chipselect), 32'd1);
      check("t3_wn",    32'(avm_if.avm_write_n),    32'd0);
      check("t3_wdata", avm_if.avm_writedata,       32'h0000AAAA);
      check("t3_ack",   32'(ack),                   32'd0);
    end
    next_cyc();
    avm_if.avm_waitrequest = 1'b0;
    sample();
    next_cyc();
    sample();
    check("t3_ack_after_wait", 32'(ack), 32'b0100);
    req = '0;
    next_cyc();
    sample();
    check("t3_shadow", 32'(led_shadow), 32'h0AAAA);

    // Reset lands mid-WRITE: outputs drop immediately, no ack afterwards.
    avm_if.avm_waitrequest = 1'b1;
    set_data(3, 17'h00F0F);
    req = 4'b1000;
    next_cyc();
    sample();
    check("t4_in_write", 32'(avm_if.avm_chipselect), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("t4_reset");
    next_cyc();
    reset = 1'b0;
    req   = '0;
    avm_if.avm_waitrequest = 1'b0;
    repeat (3) begin
      sample();
      check("t4_no_ack", 32'(ack), 32'd0);
    end
    check("t4_shadow", 32'(led_shadow), 32'd0);

    // Requester 1 drops req during WRITE: write and ack still happen.
    next_cyc();
    set_data(1, 17'h00055);
    req = 4'b0010;
    exp_q.push_back('{32'h00000055, 1});
    next_cyc();
    req = '0;
    sample();
    next_cyc();
    sample();
    check("t5_ack", 32'(ack), 32'b0010);
    next_cyc();
    sample();
    check("t5_shadow", 32'(led_shadow), 32'h00055);
    check("t5_idle",   32'(busy),       32'd0);

`ifdef LED_BLINK_EN
    // Blink with no requesters: shadow toggles 3,0,3.
    do_reset();
    blink_mask = 17'h00003;
    exp_q.push_back('{32'h3, -1});
    exp_q.push_back('{32'h0, -1});
    exp_q.push_back('{32'h3, -1});
    wait_empty("t6_blink_timeout", 60);
    next_cyc();
    sample();
    check("t6_shadow_blink", 32'(led_shadow), 32'h3);

    // Blink held off by a busy requester; pending ticks coalesce into one write.
    do_reset();
    set_data(0, 17'h12345);
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{32'h12345, 0});
    req = 4'b0001;
    for (int k = 0; k < 6; k++)
      wait_ack("t6_req_ack_timeout");
    req = '0;
    exp_q.push_back('{32'h12346, -1});
    wait_empty("t6_coalesce_timeout", 20);
    blink_mask = '0;
    repeat (24) next_cyc();
    sample();
    check("t6_shadow_mask0", 32'(led_shadow), 32'h12346);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
